// File: rtl/move_input_debouncer_if.sv
// move_input_debouncer_if: raw button inputs and move strobe/status outputs
interface move_input_debouncer_if;
    logic       ar;
    logic       ab;
    logic       iz;
    logic       de;
    logic [3:0] dir;
    logic       held;
    modport master(output ar, ab, iz, de, input dir, held);
    modport slave(input ar, ab, iz, de, output dir, held);
endinterface

// File: rtl/move_input_debouncer.sv
// move_input_debouncer: synchronise, debounce and turn button presses into one-hot move strobes
module move_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1
) (
    input logic                   clk,
    input logic                   rst,
    move_input_debouncer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FIRE, WAIT_REL} state_t;
    localparam logic [3:0]       REL  = ACTIVE_LOW ? 4'hf : 4'h0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [3:0]       raw, m, y, p, s, code, code_n;
    logic [CNT_W-1:0] c [4];
    state_t           state, state_n;
    assign raw = {bus.ar, bus.ab, bus.iz, bus.de};
    assign p   = ACTIVE_LOW ? ~y : y;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            m <= REL;
            y <= REL;
        end else begin
            m <= raw;
            y <= m;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s <= '0;
            for (int k = 0; k < 4; k++) c[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (p[k] == s[k]) c[k] <= '0;
                else if (c[k] == LAST) begin
                    s[k] <= p[k];
                    c[k] <= '0;
                end else c[k] <= c[k] + CNT_W'(1);
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            code  <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
        end
    // multi-button s in IDLE is ambiguous: skip the strobe and wait for full release
    always_comb begin
        state_n = state;
        code_n  = code;
        case (state)
            IDLE:
                if ($onehot(s)) begin
                    state_n = FIRE;
                    code_n  = s;
                end else if (s != 4'b0) state_n = WAIT_REL;
            FIRE:     state_n = WAIT_REL;
            WAIT_REL: state_n = (s == 4'b0) ? IDLE : WAIT_REL;
            default:  state_n = IDLE;
        endcase
    end
    assign bus.dir  = (state == FIRE) ? code : 4'b0;
    assign bus.held = |s;
endmodule

// File: doc/move_input_debouncer.md
# move_input_debouncer

Conditions the four raw push-button inputs (ar = up, ab = down, iz = left, de = right) for the 2048 game. For each button it synchronises the input to `clk`, debounces it, and emits exactly one single-cycle one-hot `dir` strobe per accepted press. It sits directly upstream of `controller_game` and drives its `dir` input. Ambiguous multi-button presses are rejected, and a button must be released before another move is accepted.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles a synchronised input must differ from its debounced state before the debounced state changes. 10 ms at 50 MHz. Must be ≥ 1.
- `CNT_W`, default 20: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES−1.
- `ACTIVE_LOW`, default 1: 1 means a raw input at 0 is "pressed". 0 means a raw input at 1 is "pressed".

Ports:
- `clk`  in  1: system clock. All state is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ar`  in  1: raw up button, asynchronous to `clk`.
- `ab`  in  1: raw down button, asynchronous to `clk`.
- `iz`  in  1: raw left button, asynchronous to `clk`.
- `de`  in  1: raw right button, asynchronous to `clk`.
- `dir`  out  4: one-hot move strobe. Bit 3 = up, bit 2 = down, bit 1 = left, bit 0 = right. 4'b0000 means no move.
- `held`  out  1: high while any debounced button is pressed. Status only.

## Operation
- **Synchroniser.** Each raw input passes through a 2-flop synchroniser. The flops reset to the released level (1 if ACTIVE_LOW=1, else 0). The polarity-corrected result is `p[i]`, with 1 meaning pressed.
- **Debouncer.** Each button has its own debounced bit `s[i]` (reset 0) and counter `c[i]` (reset 0).
  - If `p[i]` equals `s[i]`: `c[i]` is set to 0.
  - If `p[i]` differs from `s[i]` and `c[i]` equals DEBOUNCE_CYCLES−1: `s[i]` is set to `p[i]` and `c[i]` is set to 0.
  - If `p[i]` differs from `s[i]` otherwise: `c[i]` increments by 1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles therefore never reaches `s[i]`.
- **Press FSM.** Registered states are IDLE, FIRE and WAIT_REL. Reset state is IDLE.
  - IDLE, when `s` is exactly one-hot: latch `s` into `code` and go to FIRE.
  - IDLE, when `s` has two or more bits set: go to WAIT_REL. No strobe is emitted.
  - IDLE, when `s` is 0: stay in IDLE.
  - FIRE: always go to WAIT_REL on the next cycle.
  - WAIT_REL, when `s` is 4'b0000: go to IDLE.
  - WAIT_REL, otherwise: stay. Extra presses or changes of the held button emit nothing.
- **Outputs.**
  - `dir` = `code` when the state is FIRE, else 4'b0000. It is registered (Moore) and never has more than one bit set.
  - `held` = OR of `s`, registered with `s`.
- **Reset.**
  - Asserting `rst` at any time, including mid-count or in FIRE, immediately clears all counters, `s`, `code` and the state. `dir` = 0, `held` = 0 and the state is IDLE.
  - A button held through reset release counts as a new press: after debouncing it produces one strobe.

## Timing
- Count clock edges from the first edge at which the raw input has its new stable value (edge 0).
  - Synchronised `p[i]` changes at edge 2.
  - `s[i]` changes at edge 2+DEBOUNCE_CYCLES.
  - The FSM enters FIRE at edge 3+DEBOUNCE_CYCLES.
  - `dir` is high for exactly one cycle, from edge 3+D to edge 4+D.
- Release latency is the same path: `s[i]` clears at edge 2+D after the raw release. IDLE is re-entered at edge 3+D.
- Minimum spacing between two strobes from the same button:
  - debounced press, then debounced release, then debounced press;
  - at least 2·DEBOUNCE_CYCLES + 2 cycles.
- Two buttons whose `s` bits set on the same edge are treated as an ambiguous press: no strobe.
- Two buttons whose `s` bits set on different edges: the first produces a strobe, the second is ignored until all buttons are released.
- There is no combinational path from any input to any output.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1, with all raw inputs idle at 1.
- **Reset values.** Hold `rst`=0 with `ar`=0, then release `rst`.
  - During reset: `dir`=0 and `held`=0.
  - After release: `dir`=4'b1000 exactly 7 edges later, for 1 cycle.
- **Clean press.** Drive `de`=0 at edge 0 and hold it.
  - `dir`=4'b0001 only in the cycle after edge 7.
  - `held`=1 from edge 6.
  - Holding `de` for 100 more cycles produces no further strobe.
- **Bounce rejection.** Toggle `iz` as 0 for 3 cycles, 1 for 1 cycle, 0 for 3 cycles, then release.
  - `dir` stays 0 throughout and `held` never rises.
- **Ambiguous press.** Drive `ar`=0 and `ab`=0 on the same edge and hold them.
  - `dir` stays 0.
  - After both are released for ≥7 cycles, an `ab`-only press gives `dir`=4'b0100.
- **Second press ignored.** Press `ab`, then press `de` 20 cycles later while `ab` is still held.
  - Exactly one strobe, `dir`=4'b0100.
  - Release both, then press `de`: one strobe, `dir`=4'b0001.
- **Reset mid-operation.** Assert `rst` while the state is FIRE.
  - `dir` drops to 0 immediately, without waiting for a clock edge.
  - After `rst` is released with no button held, no strobe occurs.
